// File: rtl/wbh_pkg.sv
// Shared definitions for the byte-stream to Wishbone host bridge:
// command/response codes and the bridge FSM state encoding.
package wbh_pkg;

  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] RSP_OK  = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    WDATA,
    BUS,
    RESP
  } state_t;

endpackage

// File: rtl/wb_host_bridge_if.sv
// Wishbone-side bundle of the host bridge; the bridge is the master,
// the memory/register fabric is the slave.
interface wb_host_bridge_if #(
  parameter int AW = 16
);

  logic [AW-1:0] wb_addr;
  logic [31:0]   wb_wdata;
  logic [3:0]    wb_wmsk;
  logic          wb_we;
  logic          wb_cyc;
  logic [31:0]   wb_rdata;
  logic          wb_ack;

  modport master (
    output wb_addr,
    output wb_wdata,
    output wb_wmsk,
    output wb_we,
    output wb_cyc,
    input  wb_rdata,
    input  wb_ack
  );

  modport slave (
    input  wb_addr,
    input  wb_wdata,
    input  wb_wmsk,
    input  wb_we,
    input  wb_cyc,
    output wb_rdata,
    output wb_ack
  );

endinterface

// File: rtl/wb_host_bridge.sv
// Byte-stream command decoder driving single Wishbone word accesses.
// Define WBH_TIMEOUT_EN to abort a stuck bus cycle with an 0xEE reply.
module wb_host_bridge
  import wbh_pkg::*;
#(
  parameter int AW        = 16,
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_stb,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ack,
  output logic       busy,
  wb_host_bridge_if.master wb
);

  state_t      state_q;
  state_t      state_d;
  logic        we_q;
  logic        err_q;
  logic        cyc_q;
  logic [1:0]  cnt_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;

  logic bus_ack;
  logic tx_fire;
  logic last_byte;
  logic cmd_ok;
  logic to_hit;

  assign bus_ack   = cyc_q & wb.wb_ack;
  assign tx_fire   = tx_valid_q & tx_ack;
  assign last_byte = err_q | we_q | (cnt_q == 2'd3);
  assign cmd_ok    = (rx_data == CMD_WR) |
                     (rx_data == CMD_RD);

`ifdef WBH_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    {TIMEOUT_W{1'b1}} - 1'b1;

  logic [TIMEOUT_W-1:0] to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else if (state_q != BUS) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + 1'b1;
    end
  end

  // The counter reaches all-ones on the same edge that aborts the cycle.
  assign to_hit = cyc_q & ~wb.wb_ack &
                  (to_q == TO_LAST);
`else
  assign to_hit = cyc_q & (TIMEOUT_W == 0);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rx_stb && cmd_ok) begin
          state_d = ADDR_H;
        end
      end
      ADDR_H: begin
        if (rx_stb) begin
          state_d = ADDR_L;
        end
      end
      ADDR_L: begin
        if (rx_stb) begin
          state_d = we_q ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (rx_stb && cnt_q == 2'd3) begin
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus_ack || to_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (tx_fire && last_byte) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      cyc_q      <= 1'b0;
      cnt_q      <= 2'd0;
      addr_q     <= 16'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      tx_data_q  <= 8'h0;
      tx_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_stb && cmd_ok) begin
            we_q  <= (rx_data == CMD_WR);
            err_q <= 1'b0;
            cnt_q <= 2'd0;
          end
        end
        ADDR_H: begin
          if (rx_stb) begin
            addr_q[15:8] <= rx_data;
          end
        end
        ADDR_L: begin
          if (rx_stb) begin
            addr_q[7:0] <= rx_data;
            cyc_q       <= ~we_q;
          end
        end
        WDATA: begin
          if (rx_stb) begin
            wdata_q <= {wdata_q[23:0], rx_data};
            cnt_q   <= cnt_q + 2'd1;
            cyc_q   <= (cnt_q == 2'd3);
          end
        end
        BUS: begin
          if (bus_ack) begin
            cyc_q      <= 1'b0;
            tx_valid_q <= 1'b1;
            cnt_q      <= 2'd0;
            if (we_q) begin
              tx_data_q <= RSP_OK;
            end else begin
              tx_data_q <= wb.wb_rdata[31:24];
              rdata_q   <= {wb.wb_rdata[23:0], 8'h00};
            end
          end else if (to_hit) begin
            cyc_q      <= 1'b0;
            err_q      <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= RSP_ERR;
          end
        end
        RESP: begin
          if (tx_fire) begin
            if (last_byte) begin
              tx_valid_q <= 1'b0;
            end else begin
              tx_data_q <= rdata_q[31:24];
              rdata_q   <= {rdata_q[23:0], 8'h00};
              cnt_q     <= cnt_q + 2'd1;
            end
          end
        end
        default: begin
          cyc_q      <= 1'b0;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb.wb_addr  = addr_q[AW-1:0];
  assign wb.wb_wdata = wdata_q;
  assign wb.wb_wmsk  = 4'hF;
  assign wb.wb_we    = we_q;
  assign wb.wb_cyc   = cyc_q;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge: vector table plus hand sequences
// for round-trip timing, receive drops, bus wait/timeout and reset.
module tb_wb_host_bridge;
  import wbh_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_stb = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ack = 1'b0;
  logic       busy;

  wb_host_bridge_if #(.AW(16)) wb ();

  wb_host_bridge #(
    .AW(16),
    .TIMEOUT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_stb(rx_stb),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ack(tx_ack),
    .busy(busy),
    .wb(wb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Wishbone slave model
  logic        ack_en = 1'b0;
  logic        ack_comb = 1'b0;
  logic        ack_dly = 1'b0;
  logic [31:0] rdata = 32'h0;

  assign wb.wb_ack = ack_en & (ack_comb ? wb.wb_cyc : ack_dly);
  assign wb.wb_rdata = rdata;

  always @(posedge clk)
    ack_dly <= wb.wb_cyc & ~wb.wb_ack & ~ack_dly;

  int          bus_n = 0;
  int          cyc_cycles = 0;
  logic [15:0] m_addr = 16'h0;
  logic [31:0] m_wdata = 32'h0;
  logic        m_we = 1'b0;
  logic [7:0]  rxq[$];
  int          tx_unstable = 0;
  logic        hold = 1'b0;
  logic [7:0]  pdata = 8'h0;

  always @(posedge clk) begin
    if (wb.wb_cyc) cyc_cycles++;
    if (wb.wb_cyc && wb.wb_ack) begin
      bus_n++;
      m_addr  = wb.wb_addr;
      m_wdata = wb.wb_wdata;
      m_we    = wb.wb_we;
    end
    if (tx_valid && tx_ack) rxq.push_back(tx_data);
    if (hold && tx_data !== pdata) tx_unstable++;
    hold  = tx_valid && !tx_ack;
    pdata = tx_data;
  end

  // tx_ack after `stall` waiting cycles per byte
  int stall = 0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (tx_valid) begin
      if (wcnt >= stall) begin
        tx_ack = 1'b1;
        wcnt = 0;
      end else begin
        tx_ack = 1'b0;
        wcnt++;
      end
    end else begin
      tx_ack = 1'b0;
      wcnt = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic wait_cyc(input string name, input int bound);
    int n = 0;
    while (!wb.wb_cyc && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, wb.wb_cyc, 1'b1);
  endtask

  task automatic wait_txv(input string name, input int bound);
    int n = 0;
    while (!tx_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, tx_valid, 1'b1);
  endtask

  task automatic chk_bytes(input string name,
                           input logic [31:0] exp,
                           input int n);
    logic [7:0] got;
    logic [7:0] want;
    chk({name, "_n"}, rxq.size(), n);
    for (int i = 0; i < n; i++) begin
      got  = (i < rxq.size()) ? rxq[i] : 8'hxx;
      want = 8'(exp >> (8 * (n - 1 - i)));
      chk($sformatf("%s_b%0d", name, i), got, want);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          comb;
    int          stall;
    bit          junk;
    logic [31:0] exp_rsp;
    int          exp_n;
    logic        exp_we;
    int          exp_cyc;
  } vec_t;

  vec_t tv[5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int b0;
    int c0;

    tv[0] = '{8'h01, 16'h0012, 32'hDEADBEEF, 32'h0,
              1'b0, 0, 1'b0, 32'h000000AA, 1, 1'b1, 2};
    tv[1] = '{8'h02, 16'h0034, 32'h0, 32'h01020304,
              1'b1, 3, 1'b0, 32'h01020304, 4, 1'b0, 1};
    tv[2] = '{8'h02, 16'h0001, 32'h0, 32'hA5A55A5A,
              1'b0, 1, 1'b1, 32'hA5A55A5A, 4, 1'b0, 2};
    tv[3] = '{8'h01, 16'hFFFF, 32'h00000000, 32'h0,
              1'b1, 2, 1'b0, 32'h000000AA, 1, 1'b1, 1};
    tv[4] = '{8'h02, 16'h0000, 32'h0, 32'hFFFFFFFF,
              1'b0, 0, 1'b0, 32'hFFFFFFFF, 4, 1'b0, 2};

    // reset state
    #12;
    chk("rst_cyc", wb.wb_cyc, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_addr", wb.wb_addr, 16'h0);
    chk("rst_wdata", wb.wb_wdata, 32'h0);
    chk("rst_we", wb.wb_we, 1'b0);
    chk("wmsk", wb.wb_wmsk, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // minimum round trip: back-to-back frame, comb ack, tx_ack high
    ack_en = 1'b1;
    ack_comb = 1'b1;
    stall = 0;
    rxq.delete();
    foreach (tv[0].cmd[i]) ;
    begin
      logic [7:0] fr[7];
      fr = '{8'h01, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        rx_data = fr[i];
        rx_stb = 1'b1;
      end
    end
    @(negedge clk);
    rx_stb = 1'b0;
    chk("rt_cyc_n1", wb.wb_cyc, 1'b1);
    chk("rt_txv_n1", tx_valid, 1'b0);
    chk("rt_wdata", wb.wb_wdata, 32'h11223344);
    @(negedge clk);
    chk("rt_cyc_n2", wb.wb_cyc, 1'b0);
    chk("rt_txv_n2", tx_valid, 1'b1);
    chk("rt_txd_n2", tx_data, 8'hAA);
    @(negedge clk);
    chk("rt_busy_n3", busy, 1'b0);
    chk("rt_txv_n3", tx_valid, 1'b0);
    chk_bytes("rt_rsp", 32'hAA, 1);

    // bus wait with stray bytes in BUS and RESP
    ack_en = 1'b0;
    ack_comb = 1'b1;
    stall = 1000;
    rdata = 32'h11223344;
    rxq.delete();
    b0 = bus_n;
    c0 = cyc_cycles;
    send(8'h02);
    send(8'h00);
    send(8'h40);
    wait_cyc("drop_cyc", 10);
    send(8'h01);
    send(8'h02);
    repeat (30) @(negedge clk);
`ifndef WBH_TIMEOUT_EN
    chk("nto_cyc", wb.wb_cyc, 1'b1);
    chk("nto_busy", busy, 1'b1);
    ack_en = 1'b1;
`else
    chk("to_cyc", wb.wb_cyc, 1'b0);
    chk("to_len", cyc_cycles - c0, 15);
    ack_en = 1'b1;
`endif
    wait_txv("drop_txv", 10);
    send(8'h01);
    send(8'h00);
    stall = 3;
    wait_idle("drop_idle", 100);
`ifndef WBH_TIMEOUT_EN
    chk("drop_bus_n", bus_n - b0, 1);
    chk("drop_addr", m_addr, 16'h0040);
    chk_bytes("drop_rsp", 32'h11223344, 4);
`else
    chk("to_bus_n", bus_n - b0, 0);
    chk_bytes("to_rsp", 32'hEE, 1);
`endif
    chk("drop_stable", tx_unstable, 0);

    // vector table
    for (int v = 0; v < 5; v++) begin
      ack_en = 1'b1;
      ack_comb = tv[v].comb;
      stall = tv[v].stall;
      rdata = tv[v].rdata;
      rxq.delete();
      tx_unstable = 0;
      b0 = bus_n;
      c0 = cyc_cycles;
      if (tv[v].junk) begin
        send(8'h55);
        send(8'hFF);
        send(8'h00);
        chk($sformatf("v%0d_junk_busy", v), busy, 1'b0);
      end
      send(tv[v].cmd);
      send(tv[v].addr[15:8]);
      send(tv[v].addr[7:0]);
      if (tv[v].cmd == CMD_WR) begin
        for (int i = 3; i >= 0; i--)
          send(8'(tv[v].wdata >> (8 * i)));
      end
      wait_idle($sformatf("v%0d_idle", v), 200);
      chk($sformatf("v%0d_bus_n", v), bus_n - b0, 1);
      chk($sformatf("v%0d_addr", v), m_addr, tv[v].addr);
      chk($sformatf("v%0d_we", v), m_we, tv[v].exp_we);
      if (tv[v].exp_we)
        chk($sformatf("v%0d_wdata", v), m_wdata, tv[v].wdata);
      chk($sformatf("v%0d_cyc_len", v),
          cyc_cycles - c0, tv[v].exp_cyc);
      chk_bytes($sformatf("v%0d_rsp", v),
                tv[v].exp_rsp, tv[v].exp_n);
      chk($sformatf("v%0d_stable", v), tx_unstable, 0);
    end

    // reset while wb_cyc is high
    ack_en = 1'b0;
    stall = 0;
    send(8'h02);
    send(8'h00);
    send(8'h50);
    wait_cyc("rstm_cyc_up", 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_cyc", wb.wb_cyc, 1'b0);
    chk("rstm_txv", tx_valid, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    ack_comb = 1'b0;
    rdata = 32'hCAFE0001;
    rxq.delete();
    b0 = bus_n;
    send(8'h02);
    send(8'h00);
    send(8'h05);
    wait_idle("rstm_idle", 100);
    chk("rstm_bus_n", bus_n - b0, 1);
    chk("rstm_addr", m_addr, 16'h0005);
    chk("rstm_we", m_we, 1'b0);
    chk_bytes("rstm_rsp", 32'hCAFE0001, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_host_bridge.md
WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

Interface
REQ-001 Parameter AW, default 16: Wishbone word-address width, 1..16; carried as two address bytes; upper unused bits ignored.
REQ-002 Parameter TIMEOUT_W, default 8: width of the ack-timeout counter.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received command-stream byte.
REQ-006 rx_stb  input  1  one-cycle strobe; rx_data is valid in this cycle.
REQ-007 tx_data  output  8  response byte.
REQ-008 tx_valid  output  1  tx_data is valid and held until accepted.
REQ-009 tx_ack  input  1  byte accepted when tx_valid & tx_ack.
REQ-010 wb_addr  output  AW  Wishbone word address.
REQ-011 wb_wdata  output  32  write data.
REQ-012 wb_wmsk  output  4  byte mask, always 4'hF.
REQ-013 wb_we  output  1  write enable.
REQ-014 wb_cyc  output  1  cycle request.
REQ-015 wb_rdata  input  32  read data, sampled when wb_ack is high.
REQ-016 wb_ack  input  1  cycle acknowledge; may be combinational from wb_cyc.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 FSM states: IDLE, ADDR_H, ADDR_L, WDATA, BUS, RESP.
REQ-019 IDLE: a byte of 0x01 latches write mode and moves to ADDR_H; 0x02 latches read mode and moves to ADDR_H; any other byte is discarded and the FSM stays in IDLE.
REQ-020 ADDR_H and ADDR_L: each takes one byte into address bits [15:8] and [7:0]. Write mode then goes to WDATA; read mode goes to BUS.
REQ-021 WDATA: takes 4 bytes MSB first into wb_wdata, using a 2-bit counter, then goes to BUS.
REQ-022 wb_cyc is registered and rises exactly one clock after the rx_stb of the final frame byte.
REQ-023 In BUS, wb_cyc, wb_we, wb_addr and wb_wdata stay stable until wb_ack is sampled high.
REQ-024 wb_ack is ignored while wb_cyc is low.
REQ-025 On the edge where wb_ack is sampled high: wb_cyc clears, wb_rdata is captured (read mode only), and the FSM enters RESP.
REQ-026 Write response: a single byte 0xAA.
REQ-027 Read response: the 4 captured bytes, MSB first.
REQ-028 RESP: tx_valid is registered; tx_data is stable while tx_valid & ~tx_ack; the next byte is presented no earlier than the cycle after acceptance.
REQ-029 RESP returns to IDLE the cycle after the last byte is accepted.
REQ-030 rx_stb is dropped silently in BUS and RESP; there is no back-pressure on the receive side.
REQ-031 Minimum round trip for a write with combinational ack and tx_ack tied high: cyc on cycle N+1, tx_valid on N+2, IDLE on N+3.

Reset
REQ-032 Asynchronous assertion; all outputs are low and the FSM is in IDLE immediately.
REQ-033 Reset values: wb_addr, wb_wdata, tx_data, counters = 0; busy = 0.
REQ-034 Reset mid-cycle or mid-response abandons the transaction; the next frame after release is processed normally.

Configuration
REQ-035 Macro WBH_TIMEOUT_EN.
- Defined: a TIMEOUT_W-bit counter clears on entry to BUS and increments every BUS cycle.
- At all-ones without ack, wb_cyc clears and the response is the single byte 0xEE, for both reads and writes.
- A late wb_ack after timeout is ignored.
REQ-036 Macro undefined: no timeout counter is present, BUS waits indefinitely, and 0xEE is never emitted.

Structure
REQ-037 Shared package wbh_pkg holds:
- command codes CMD_WR = 8'h01 and CMD_RD = 8'h02;
- response codes RSP_OK = 8'hAA and RSP_ERR = 8'hEE;
- the FSM state encoding.
REQ-038 Single module; no sub-module. Byte transport comes from the existing UART core, instantiated outside this block.

Verification
REQ-039 Write: frame 01 00 12 DE AD BE EF with ack 1 cycle after cyc -> one cycle with wb_addr = 0x0012, wb_wdata = 0xDEADBEEF, we = 1; response AA.
REQ-040 Read: frame 02 00 34 with ack carrying wb_rdata = 0x01020304 -> we = 0; responses 01 02 03 04 in order, with tx_ack stalled 3 cycles per byte and tx_data stable throughout.
REQ-041 Garbage: bytes 55 FF 00 then 02 00 01 -> first three bytes ignored, a single read at 0x0001.
REQ-042 Timeout, WBH_TIMEOUT_EN defined, TIMEOUT_W = 4, ack never given -> cyc drops after 15 BUS cycles; response EE; a later ack has no effect.
REQ-043 Reset: assert rst_n low while wb_cyc is high -> cyc, tx_valid and busy go low asynchronously; a following frame 02 00 05 completes correctly.
REQ-044 Drop: rx_stb during BUS and RESP -> bytes discarded; the following frame decodes normally.
